cs_window_filter: RTL

//  Parametrised sliding-window "competitive selection" filter for streamed samples.

---
 rtl/cs_pkg.sv | 29 ++
 rtl/cs_max_le.sv | 57 +++++
 rtl/cs_window_filter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cs_pkg.sv
// cs_pkg: shared definitions for the competitive-selection window filter.
//   - clog2(): ceiling log2, used to size SUM, the fill counter and the max tree.
//   - CS_MODE_*: output-select encodings; 3 behaves like CS_MODE_CS.
//   - CS_DEF_*: default DW / N / SHIFT / OW parameter values.
package cs_pkg;

    localparam int CS_DEF_DW    = 8;
    localparam int CS_DEF_N     = 9;
    localparam int CS_DEF_SHIFT = 3;
    localparam int CS_DEF_OW    = 10;

    localparam logic [1:0] CS_MODE_CS    = 2'd0;
    localparam logic [1:0] CS_MODE_AVG   = 2'd1;
    localparam logic [1:0] CS_MODE_XAPPR = 2'd2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cs_max_le.sv
// cs_max_le: combinational reduction tree returning the largest flagged value.
//   val_i  in  N x DW  candidate values
//   le_i   in  N       per-value select flags
//   any_o  out 1       OR of all flags
//   max_o  out DW      max of values whose flag is set (0 when no flag is set)
// The tree is stored heap-style: node k combines children 2k and 2k+1, leaves
// start at index P (N rounded up to a power of two); padding leaves are empty.
module cs_max_le
    import cs_pkg::*;
#(
    parameter int DW = CS_DEF_DW,
    parameter int N  = CS_DEF_N
) (
    input  logic [DW-1:0] val_i [N],
    input  logic [N-1:0]  le_i,
    output logic          any_o,
    output logic [DW-1:0] max_o
);

    localparam int P = 1 << clog2(N);

    logic [DW-1:0] node_val [1:2*P-1];
    logic          node_flg [1:2*P-1];

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so
        // no path leaves a value unassigned and no latch is inferred.
        for (int k = 1; k < 2 * P; k++) begin
            node_val[k] = '0;
            node_flg[k] = 1'b0;
        end

        for (int i = 0; i < N; i++) begin
            node_flg[P + i] = le_i[i];
            node_val[P + i] = le_i[i] ? val_i[i] : '0;
        end

        // Children always have larger indices, so walking downward sees them first.
        for (int k = P - 1; k >= 1; k--) begin
            node_flg[k] = node_flg[2 * k] | node_flg[2 * k + 1];
            if (node_flg[2 * k] && node_flg[2 * k + 1]) begin
                node_val[k] = (node_val[2 * k] >= node_val[2 * k + 1]) ?
                              node_val[2 * k] : node_val[2 * k + 1];
            end else if (node_flg[2 * k]) begin
                node_val[k] = node_val[2 * k];
            end else if (node_flg[2 * k + 1]) begin
                node_val[k] = node_val[2 * k + 1];
            end else begin
                node_val[k] = '0;
            end
        end

        any_o = node_flg[1];
        max_o = node_val[1];
    end

endmodule

// File: rtl/cs_window_filter.sv
// cs_window_filter: sliding-window competitive-selection filter.
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-low reset
//   clr        in   1   synchronous clear of window, SUM, count and pipeline
//   in_valid   in   1   accept X this cycle
//   X          in   DW  unsigned sample
//   mode       in   2   0/3 = (SUM + N*XAPPR) >> SHIFT, 1 = AVG, 2 = XAPPR
//   out_valid  out  1   one-cycle pulse per result, 2 clk after acceptance
//   Y          out  OW  result, saturated to 2^OW-1
//   win_full   out  1   N samples accepted since last reset/clr
// Stage 0 shifts the window and updates SUM/count. Stage 1 snapshots the
// window with AVG and the per-sample <=AVG flags. Stage 2 reduces to XAPPR
// and registers Y.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int DW    = CS_DEF_DW,
    parameter int N     = CS_DEF_N,
    parameter int SHIFT = CS_DEF_SHIFT,
    parameter int OW    = CS_DEF_OW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] X,
    input  logic [1:0]    mode,
    output logic          out_valid,
    output logic [OW-1:0] Y,
    output logic          win_full
);

    localparam int SW = DW + clog2(N);          // SUM width
    localparam int TW = SW + 1;                 // SUM + N*XAPPR cannot wrap
    localparam int CW = clog2(N + 1);           // fill count holds 0..N
    localparam int MW = (TW > OW) ? TW : OW;    // common width for saturation
    localparam logic [CW-1:0] N_CNT   = CW'(N);
    localparam logic [CW-1:0] N_CNT_1 = CW'(N - 1);
    localparam logic [MW-1:0] Y_MAX   = MW'({OW{1'b1}});

    // Stage 0: window, running sum, fill count
    logic [DW-1:0] win_q [N];
    logic [DW-1:0] win_d [N];
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s0_valid_q, s0_valid_d;
    logic [1:0]    s0_mode_q, s0_mode_d;

    // Stage 1: snapshot of the window that produced this result
    logic          s1_valid_q, s1_valid_d;
    logic [1:0]    s1_mode_q, s1_mode_d;
    logic [SW-1:0] s1_sum_q, s1_sum_d;
    logic [SW-1:0] s1_avg_q, s1_avg_d;
    logic [DW-1:0] s1_win_q [N];
    logic [DW-1:0] s1_win_d [N];
    logic [N-1:0]  s1_le_q, s1_le_d;

    // Stage 2: outputs
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] y_q, y_d;

    // Combinational helpers
    logic [SW-1:0] avg_now;
    logic          any_le;
    logic [DW-1:0] max_le;
    logic [DW-1:0] xappr;
    logic [TW-1:0] cs_term;
    logic [TW-1:0] cs_shift;
    logic [MW-1:0] y_sel;
    logic [MW-1:0] y_sat;

    cs_max_le #(
        .DW (DW),
        .N  (N)
    ) u_max_le (
        .val_i (s1_win_q),
        .le_i  (s1_le_q),
        .any_o (any_le),
        .max_o (max_le)
    );

    // Stage 0 next state
    always_comb begin
        win_d      = win_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        s0_valid_d = 1'b0;
        s0_mode_d  = s0_mode_q;

        if (clr) begin
            for (int i = 0; i < N; i++) win_d[i] = '0;
            sum_d     = '0;
            cnt_d     = '0;
            s0_mode_d = '0;
        end else if (in_valid) begin
            win_d[0] = X;
            for (int i = 1; i < N; i++) win_d[i] = win_q[i - 1];
            // Until the window is full the departing slot is still 0.
            sum_d      = sum_q - SW'(win_q[N - 1]) + SW'(X);
            cnt_d      = (cnt_q == N_CNT) ? cnt_q : cnt_q + 1'b1;
            // Produce a result only once this sample completes (or follows) a full window.
            s0_valid_d = (cnt_q == N_CNT) || (cnt_q == N_CNT_1);
            s0_mode_d  = mode;
        end
    end

    // Stage 1 next state: AVG from the updated SUM, flags against that AVG
    always_comb begin
        avg_now    = sum_q / SW'(N);
        s1_valid_d = s0_valid_q;
        s1_mode_d  = s0_mode_q;
        s1_sum_d   = sum_q;
        s1_avg_d   = avg_now;
        s1_win_d   = win_q;
        for (int i = 0; i < N; i++) begin
            s1_le_d[i] = (SW'(win_q[i]) <= avg_now);
        end

        if (clr) begin
            s1_valid_d = 1'b0;
            s1_mode_d  = '0;
            s1_sum_d   = '0;
            s1_avg_d   = '0;
            for (int i = 0; i < N; i++) s1_win_d[i] = '0;
            s1_le_d    = '0;
        end
    end

    // Stage 2 next state: XAPPR, mode select, saturation
    always_comb begin
        // The window minimum is always <= AVG, so any_le is set for real results.
        xappr    = any_le ? max_le : '0;
        cs_term  = {1'b0, s1_sum_q} + TW'(N) * TW'(xappr);
        cs_shift = cs_term >> SHIFT;

        case (s1_mode_q)
            CS_MODE_AVG:   y_sel = MW'(s1_avg_q);
            CS_MODE_XAPPR: y_sel = MW'(xappr);
            default:       y_sel = MW'(cs_shift);
        endcase
        y_sat = (y_sel > Y_MAX) ? Y_MAX : y_sel;

        out_valid_d = s1_valid_q;
        y_d         = s1_valid_q ? OW'(y_sat) : y_q;

        if (clr) begin
            out_valid_d = 1'b0;
            y_d         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the window and its stage-1 snapshot are flops, not RAM, and
            // SUM relies on empty slots reading 0, so they are cleared on reset.
            for (int i = 0; i < N; i++) begin
                win_q[i]    <= '0;
                s1_win_q[i] <= '0;
            end
            sum_q       <= '0;
            cnt_q       <= '0;
            s0_valid_q  <= 1'b0;
            s0_mode_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= '0;
            s1_sum_q    <= '0;
            s1_avg_q    <= '0;
            s1_le_q     <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge
            // values, so stage 1 sees the old window while stage 0 shifts it.
            win_q       <= win_d;
            s1_win_q    <= s1_win_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            s0_valid_q  <= s0_valid_d;
            s0_mode_q   <= s0_mode_d;
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_sum_q    <= s1_sum_d;
            s1_avg_q    <= s1_avg_d;
            s1_le_q     <= s1_le_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign win_full  = (cnt_q == N_CNT);

endmodule
